risc_v_mike_uart_mmio: RTL
==========================

# risc_v_mike_uart_mmio

Memory-mapped UART responder on the RISC-V data bus. Decodes a 16-byte register window, buffers outgoing bytes in a TX FIFO and incoming bytes in an RX FIFO, and runs the send/flag-clear handshakes with the UART_MIKE core so software only does plain loads/stores. Sits beside `risc_v_mike_data_memory` and replaces hand-driven GPIO bit-banging of `tx_send`, `rx_flag_clr` and `tx_flag_clr`.

## Interface
- ADDR_BASE, 32'h0000_0100, byte base of window; bits [3:0] must be 0
- FIFO_DEPTH, 8, entries per FIFO; power of two, >= 2
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- bus_addr  in  32  byte address (ALU result)
- bus_write  in  1  store strobe
- bus_read  in  1  load strobe (asserted only for load instructions)
- bus_wr_data  in  32  store data
- bus_rd_data  out  32  combinational read data; 0 when not selected
- bus_sel  out  1  combinational address hit
- uart_tx_data  out  8  byte to UART core
- uart_tx_send  out  1  one-cycle send pulse
- uart_tx_flag  in  1  UART frame-sent flag (sticky until cleared)
- uart_tx_flag_clr  out  1  one-cycle clear of uart_tx_flag
- uart_rx_data  in  8  received byte
- uart_rx_flag  in  1  UART byte-received flag (sticky until cleared)
- uart_rx_flag_clr  out  1  one-cycle clear of uart_rx_flag
- irq  out  1  level interrupt

## Operation
- Hit: bus_addr[31:4] == ADDR_BASE[31:4]; register = bus_addr[3:2]. No hit: no side effects.
- 0x0 TXDATA: store pushes bus_wr_data[7:0] to TX FIFO; if full, byte dropped, TX_OVF set. Reads 0.
- 0x4 RXDATA: load returns {24'b0, RX FIFO head} and pops at clock edge; empty -> returns 0, no pop. Stores ignored.
- 0x8 STATUS (R): [0] rx_valid, [1] rx_full, [2] tx_full, [3] tx_empty, [4] tx_busy (TX FSM not TX_IDLE or TX FIFO non-empty), [5] RX_OVR sticky, [6] TX_OVF sticky, others 0. Store: write-1-to-clear bits 5,6.
- 0xC CTRL (RW): [0] rx_irq_en, [1] txdone_irq_en; store bit [2]=1 flushes both FIFOs (self-clearing, reads 0).
- irq = (rx_irq_en & rx_valid) | (txdone_irq_en & ~tx_busy).
- TX FSM: TX_IDLE -> TX_SEND when FIFO non-empty and uart_tx_flag==0 (pop head into uart_tx_data register); TX_SEND (uart_tx_send=1, one cycle) -> TX_WAIT; TX_WAIT holds until uart_tx_flag==1 -> TX_CLR; TX_CLR (uart_tx_flag_clr=1, one cycle) -> TX_IDLE. uart_tx_data stable from TX_SEND through TX_CLR.
- RX FSM: RX_IDLE with uart_rx_flag==1 -> push uart_rx_data (if full and no simultaneous pop: drop, set RX_OVR) -> RX_ACK; RX_ACK (uart_rx_flag_clr=1, one cycle) -> RX_WAIT; RX_WAIT holds until uart_rx_flag==0 -> RX_IDLE.
- FIFOs: pointers FIFO_DEPTH-wrap, count 0..FIFO_DEPTH. Simultaneous push+pop: both succeed, count unchanged, including when full (RX full + RXDATA load + incoming byte: no overrun). Push when empty + pop same cycle: pop returns 0, push lands.
- Flush: counts and pointers zeroed; flush wins over a same-cycle push/pop. TX frame in flight completes normally; sticky bits unaffected.
- Same-cycle STATUS W1C and new overrun event: set wins.

## Timing
- Reset (rst high at edge): FIFOs empty, both FSMs idle, CTRL=0, sticky bits 0; uart_tx_data=0, uart_tx_send=0, uart_tx_flag_clr=0, uart_rx_flag_clr=0, irq=0. Reset mid-frame abandons the byte; UART flags are not cleared by this block.
- bus_rd_data, bus_sel combinational, valid same cycle as bus_addr; all state updates at rising edge.
- TX latency: store at edge E0 into empty FIFO with FSM idle -> TX_SEND entered at E1, uart_tx_send high E1..E2, TX_WAIT from E2.
- Back-to-back TX minimum: TX_CLR cycle plus one TX_IDLE cycle where uart_tx_flag is observed 0.
- RX latency: uart_rx_flag high sampled at E0 -> byte in FIFO and rx_valid=1 after E0; uart_rx_flag_clr high E0..E1.
- STATUS/irq reflect post-edge state; irq has no extra register stage.

## Test plan
- Reset: assert rst 2 cycles mid-TX_WAIT -> all outputs 0, STATUS reads 32'h0000_0008, TX FSM idle.
- TX: store 0x41,0x42 to 0x100 -> uart_tx_send pulses with uart_tx_data 0x41 then 0x42, each after model raises uart_tx_flag and sees one-cycle uart_tx_flag_clr; STATUS[4] 0 afterward.
- TX overflow: 9 stores with UART stalled (uart_tx_flag held 0), FIFO_DEPTH=8 -> first byte in TX_WAIT, 8 queued, none dropped; 10th store sets STATUS[6]; W1C 0x40 clears it.
- RX: model delivers 0x5A, 0xA5 -> one-cycle uart_rx_flag_clr each; loads of 0x104 return 0x5A, 0xA5, then 0 with STATUS[0]=0.
- RX full boundary: fill 8 bytes, deliver 9th in same cycle as RXDATA load -> no STATUS[5]; deliver 10th without load -> STATUS[5]=1, FIFO content unchanged.
- IRQ/flush: CTRL=0x1, deliver byte -> irq=1; store CTRL=0x4 -> rx_valid=0, irq=0, CTRL reads 0x1.

Source files
------------

// File: rtl/risc_v_mike_uart_mmio.sv
// Purpose: MMIO register window that bridges RISC-V loads/stores to a UART core through TX/RX FIFOs.
// Latency: bus reads are combinational; state updates on the next edge; a TX store reaches uart_tx_send one edge later.
// Backpressure: a store to a full TX FIFO is dropped and sets TX_OVF; an RX byte arriving into a full FIFO is dropped and sets RX_OVR.

module risc_v_mike_uart_mmio_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [W-1:0]               i_push_dat,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head_dat,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_pop;
    logic          w_do_push;

    // A pop frees a slot in the same cycle, so push+pop on a full FIFO both succeed.
    assign w_do_pop   = i_pop && (r_count != '0);
    assign w_do_push  = i_push && ((r_count != CNT_FULL) || w_do_pop);
    assign o_drop     = i_push && !w_do_push && !i_flush;
    assign o_head_dat = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count    = r_count;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
    end
endmodule

module risc_v_mike_uart_mmio #(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0100,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [31:0] bus_wr_data,
    output logic [31:0] bus_rd_data,
    output logic        bus_sel,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_send,
    input  logic        uart_tx_flag,
    output logic        uart_tx_flag_clr,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_flag,
    output logic        uart_rx_flag_clr,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_SEND = 2'd1;
    localparam logic [1:0] TX_WAIT = 2'd2;
    localparam logic [1:0] TX_CLR  = 2'd3;
    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_ACK  = 2'd1;
    localparam logic [1:0] RX_WAIT = 2'd2;

    logic [1:0]    r_tx_state;
    logic [1:0]    r_rx_state;
    logic [7:0]    r_tx_data;
    logic [1:0]    r_ctrl;
    logic          r_rx_ovr;
    logic          r_tx_ovf;

    logic          w_wr, w_rd, w_flush, w_stat_wr, w_ctrl_wr;
    logic          w_tx_push, w_tx_start, w_tx_drop;
    logic          w_rx_push, w_rx_pop, w_rx_drop;
    logic [7:0]    w_tx_head, w_rx_head;
    logic [CW-1:0] w_tx_count, w_rx_count;
    logic          w_rx_valid, w_rx_full, w_tx_full, w_tx_empty, w_tx_busy;
    logic [31:0]   w_status;
    logic          w_unused;

    assign bus_sel    = (bus_addr[31:4] == ADDR_BASE[31:4]);
    assign w_wr       = bus_write && bus_sel;
    assign w_rd       = bus_read && bus_sel;
    assign w_tx_push  = w_wr && (bus_addr[3:2] == 2'd0);
    assign w_rx_pop   = w_rd && (bus_addr[3:2] == 2'd1);
    assign w_stat_wr  = w_wr && (bus_addr[3:2] == 2'd2);
    assign w_ctrl_wr  = w_wr && (bus_addr[3:2] == 2'd3);
    assign w_flush    = w_ctrl_wr && bus_wr_data[2];
    assign w_unused   = &{1'b0, bus_addr[1:0], bus_wr_data[31:8], bus_wr_data[4:3]};

    assign w_tx_start = (r_tx_state == TX_IDLE) && (w_tx_count != '0) && !uart_tx_flag && !w_flush;
    assign w_rx_push  = (r_rx_state == RX_IDLE) && uart_rx_flag;

    risc_v_mike_uart_mmio_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .i_flush(w_flush),
        .i_push(w_tx_push), .i_push_dat(bus_wr_data[7:0]), .i_pop(w_tx_start),
        .o_head_dat(w_tx_head), .o_count(w_tx_count), .o_drop(w_tx_drop)
    );

    risc_v_mike_uart_mmio_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .i_flush(w_flush),
        .i_push(w_rx_push), .i_push_dat(uart_rx_data), .i_pop(w_rx_pop),
        .o_head_dat(w_rx_head), .o_count(w_rx_count), .o_drop(w_rx_drop)
    );

    assign w_rx_valid = (w_rx_count != '0);
    assign w_rx_full  = (w_rx_count == CNT_FULL);
    assign w_tx_full  = (w_tx_count == CNT_FULL);
    assign w_tx_empty = (w_tx_count == '0);
    assign w_tx_busy  = (r_tx_state != TX_IDLE) || !w_tx_empty;
    assign w_status   = {25'b0, r_tx_ovf, r_rx_ovr, w_tx_busy, w_tx_empty, w_tx_full, w_rx_full, w_rx_valid};

    always_comb begin
        bus_rd_data = 32'b0;
        if (bus_sel) begin
            case (bus_addr[3:2])
                2'd1:    bus_rd_data = {24'b0, w_rx_head};
                2'd2:    bus_rd_data = w_status;
                2'd3:    bus_rd_data = {30'b0, r_ctrl};
                default: bus_rd_data = 32'b0;
            endcase
        end
    end

    assign uart_tx_data     = r_tx_data;
    assign uart_tx_send     = (r_tx_state == TX_SEND);
    assign uart_tx_flag_clr = (r_tx_state == TX_CLR);
    assign uart_rx_flag_clr = (r_rx_state == RX_ACK);
    assign irq              = (r_ctrl[0] && w_rx_valid) || (r_ctrl[1] && !w_tx_busy);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_data  <= 8'h00;
        end else begin
            case (r_tx_state)
                TX_IDLE: if (w_tx_start) begin
                    r_tx_state <= TX_SEND;
                    r_tx_data  <= w_tx_head;
                end
                TX_SEND: r_tx_state <= TX_WAIT;
                TX_WAIT: if (uart_tx_flag) r_tx_state <= TX_CLR;
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
        end else begin
            case (r_rx_state)
                RX_IDLE: if (uart_rx_flag) r_rx_state <= RX_ACK;
                RX_ACK:  r_rx_state <= RX_WAIT;
                RX_WAIT: if (!uart_rx_flag) r_rx_state <= RX_IDLE;
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // A flush store leaves the enables untouched; only a plain store rewrites them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl   <= 2'b00;
            r_rx_ovr <= 1'b0;
            r_tx_ovf <= 1'b0;
        end else begin
            if (w_ctrl_wr && !bus_wr_data[2]) r_ctrl <= bus_wr_data[1:0];
            r_rx_ovr <= w_rx_drop || (r_rx_ovr && !(w_stat_wr && bus_wr_data[5]));
            r_tx_ovf <= w_tx_drop || (r_tx_ovf && !(w_stat_wr && bus_wr_data[6]));
        end
    end
endmodule
